multicycle_ctrl: RTL and testbench

Finite-state controller for the multi-cycle RV32I datapath, successor to the single-cycle control unit. It sequences each instruction over several cycles through fetch, decode, execute, memory and writeback, sharing one ALU and one memory port. It covers the full branch set, JAL/JALR, LUI/AUIPC and a ready/valid memory handshake with wait states, and flags illegal opcodes. It sits between the instruction register/flag outputs of the datapath and every datapath mux and enable.

---
 rtl/rv_ctrl_pkg.sv | 58 +++++
 rtl/rv_alu_decoder.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: opcode constants, FSM state enum, ALU op codes, datapath mux selects.
package rv_ctrl_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_ILLEGAL
    } state_e;

    // What kind of ALU operation the current state wants.
    typedef enum logic [1:0] {
        ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_R, ALU_CLS_I
    } alu_cls_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/rv_alu_decoder.sv
// ALU operation decode from op class + funct3/funct75.
// Latency: combinational.
// Backpressure: none.
// Ports: cls_i (state class), funct3_i, funct75_i (instr[30]) -> alu_ctrl_o.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4    // at least 4; upper bits are zero
) (
    input  alu_cls_e              cls_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct75_i,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

    logic [3:0] op4;

    always_comb begin
        op4 = ALU_ADD;
        case (cls_i)
            ALU_CLS_SUB: op4 = ALU_SUB;
            ALU_CLS_R, ALU_CLS_I: begin
                case (funct3_i)
                    // instr[30] is an immediate bit for ADDI, so only R-type subtracts
                    3'b000: op4 = (cls_i == ALU_CLS_R && funct75_i) ? ALU_SUB : ALU_ADD;
                    3'b001: op4 = ALU_SLL;
                    3'b010: op4 = ALU_SLT;
                    3'b011: op4 = ALU_SLTU;
                    3'b100: op4 = ALU_XOR;
                    3'b101: op4 = funct75_i ? ALU_SRA : ALU_SRL;
                    3'b110: op4 = ALU_OR;
                    default: op4 = ALU_AND;
                endcase
            end
            default: op4 = ALU_ADD;
        endcase
    end

    assign alu_ctrl_o = ALU_CTRL_W'(op4);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: load 5, store/R/I/LUI/jump 4, branch/illegal 3 cycles, +1 per memory wait.
// Backpressure: mem_req held with stable address/write until mem_ready (if MEM_WAIT_EN).
// Ports: op/funct3/funct75 from IR, ZF/SF/VF/CF from rs1-rs2, mem_ready handshake in;
//        mem_req/mem_write, mux selects, register enables, alu_ctrl, illegal out.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct75,
    input  logic                  ZF,
    input  logic                  SF,
    input  logic                  VF,
    input  logic                  CF,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  illegal
);

    state_e   state_q, state_d;
    alu_cls_e alu_cls;
    logic     mem_ok;
    logic     taken;

    assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        illegal    = 1'b0;
        alu_cls    = ALU_CLS_ADD;
        taken      = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_LUI;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ok) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_cls   = ALU_CLS_R;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_cls   = ALU_CLS_I;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                // After a jump ALUOut holds the target, so the link value
                // oldPC+4 is recomputed and written straight from the ALU.
                if (op == OP_JAL || op == OP_JALR) begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                end else begin
                    result_src = RES_ALUOUT;
                end
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_cls    = ALU_CLS_SUB;
                result_src = RES_ALUOUT;
                state_d    = S_FETCH;
                case (funct3)
                    3'b000:         taken = ZF;
                    3'b001:         taken = !ZF;
                    3'b100:         taken = SF ^ VF;
                    3'b101:         taken = !(SF ^ VF);
                    3'b110:         taken = !CF;
                    3'b111:         taken = CF;
                    default:        state_d = S_ILLEGAL;  // 010, 011
                endcase
                pc_write = taken;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_J;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_I;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                // LUI = 0 + Uimm, AUIPC = oldPC + Uimm
                alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Quiet outputs while reset is asserted, even before the state register
        // has been forced, so no access or writeback leaks out mid-reset.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_RS2;
            imm_src    = IMM_I;
            result_src = RES_ALUOUT;
            illegal    = 1'b0;
            alu_cls    = ALU_CLS_ADD;
        end
    end

    rv_alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_dec (
        .cls_i      (alu_cls),
        .funct3_i   (funct3),
        .funct75_i  (funct75),
        .alu_ctrl_o (alu_ctrl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-computed per-cycle
// output vectors; a negedge monitor pops one whenever the DUT shows non-idle outputs.
// Instance a stalls on mem_ready; instance b ignores it (mem_ready tied low).
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_a_n, rst_b_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct75, ZF, SF, VF, CF, mem_ready;

    logic       mreq_a, mw_a, adr_a, irw_a, pcw_a, rw_a, ill_a;
    logic [1:0] sa_a, sb_a, rs_a;
    logic [2:0] imm_a;
    logic [3:0] alu_a;
    logic       mreq_b, mw_b, adr_b, irw_b, pcw_b, rw_b, ill_b;
    logic [1:0] sa_b, sb_b, rs_b;
    logic [2:0] imm_b;
    logic [3:0] alu_b;

    multicycle_ctrl #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .op(op), .funct3(funct3), .funct75(funct75),
        .ZF(ZF), .SF(SF), .VF(VF), .CF(CF), .mem_ready(mem_ready),
        .mem_req(mreq_a), .mem_write(mw_a), .adr_src(adr_a), .ir_write(irw_a),
        .pc_write(pcw_a), .reg_write(rw_a), .alu_src_a(sa_a), .alu_src_b(sb_a),
        .imm_src(imm_a), .result_src(rs_a), .alu_ctrl(alu_a), .illegal(ill_a)
    );

    multicycle_ctrl #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .op(op), .funct3(funct3), .funct75(funct75),
        .ZF(ZF), .SF(SF), .VF(VF), .CF(CF), .mem_ready(1'b0),
        .mem_req(mreq_b), .mem_write(mw_b), .adr_src(adr_b), .ir_write(irw_b),
        .pc_write(pcw_b), .reg_write(rw_b), .alu_src_a(sa_b), .alu_src_b(sb_b),
        .imm_src(imm_b), .result_src(rs_b), .alu_ctrl(alu_b), .illegal(ill_b)
    );

    logic [19:0] va, vb;
    assign va = {mreq_a, mw_a, adr_a, irw_a, pcw_a, rw_a, sa_a, sb_a, imm_a, rs_a, alu_a, ill_a};
    assign vb = {mreq_b, mw_b, adr_b, irw_b, pcw_b, rw_b, sa_b, sb_b, imm_b, rs_b, alu_b, ill_b};

    // Packs {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    //        src_a, src_b, imm_src, result_src, alu_ctrl, illegal}
    function automatic logic [19:0] ov(input int mreq, mw, adr, irw, pcw, rw,
                                       input int sa, sb, imm, rs, alu, ill);
        return {mreq[0], mw[0], adr[0], irw[0], pcw[0], rw[0],
                sa[1:0], sb[1:0], imm[2:0], rs[1:0], alu[3:0], ill[0]};
    endfunction

    localparam logic [19:0] FA   = ov(1,0,0,1,1,0, 0,2,0,0, 0,0);
    localparam logic [19:0] FW   = ov(1,0,0,0,0,0, 0,2,0,0, 0,0);
    localparam logic [19:0] DC   = ov(0,0,0,0,0,0, 1,1,2,0, 0,0);
    localparam logic [19:0] MA_L = ov(0,0,0,0,0,0, 2,1,0,0, 0,0);
    localparam logic [19:0] MA_S = ov(0,0,0,0,0,0, 2,1,1,0, 0,0);
    localparam logic [19:0] MR   = ov(1,0,1,0,0,0, 0,0,0,0, 0,0);
    localparam logic [19:0] MWB  = ov(0,0,0,0,0,1, 0,0,0,1, 0,0);
    localparam logic [19:0] MW   = ov(1,1,1,0,0,0, 0,0,0,0, 0,0);
    localparam logic [19:0] AWB  = ov(0,0,0,0,0,1, 0,0,0,0, 0,0);
    localparam logic [19:0] LWB  = ov(0,0,0,0,0,1, 1,2,0,2, 0,0);
    localparam logic [19:0] ILL  = ov(0,0,0,0,0,0, 0,0,0,0, 0,1);
    localparam logic [19:0] BR1  = ov(0,0,0,0,1,0, 2,0,0,0, 1,0);
    localparam logic [19:0] BR0  = ov(0,0,0,0,0,0, 2,0,0,0, 1,0);
    localparam logic [19:0] LUIV = ov(0,0,0,0,0,0, 3,1,4,0, 0,0);
    localparam logic [19:0] AUIV = ov(0,0,0,0,0,0, 1,1,4,0, 0,0);
    localparam logic [19:0] JALV = ov(0,0,0,0,1,0, 1,1,3,2, 0,0);
    localparam logic [19:0] JLRV = ov(0,0,0,0,1,0, 2,1,0,2, 0,0);

    typedef struct {
        int          cyc;
        logic [19:0] v;
        string       tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-idle output cycle must match the next expected entry.
    always @(negedge clk) begin
        if (va != 20'd0) begin
            n_checks++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected cyc=%0d got=%h want=nothing", cyc, va);
            end else begin
                ea = qa.pop_front();
                if (ea.cyc != cyc || ea.v != va) begin
                    n_fail++;
                    $display("FAIL a_%s got cyc=%0d out=%h want cyc=%0d out=%h",
                             ea.tag, cyc, va, ea.cyc, ea.v);
                end
            end
        end
        if (vb != 20'd0) begin
            n_checks++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected cyc=%0d got=%h want=nothing", cyc, vb);
            end else begin
                eb = qb.pop_front();
                if (eb.cyc != cyc || eb.v != vb) begin
                    n_fail++;
                    $display("FAIL b_%s got cyc=%0d out=%h want cyc=%0d out=%h",
                             eb.tag, cyc, vb, eb.cyc, eb.v);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic step(input logic rdy, input logic [19:0] v, input string tag);
        mem_ready = rdy;
        qa.push_back('{cyc, v, tag});
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic [19:0] v, input string tag);
        qb.push_back('{cyc, v, tag});
        @(posedge clk); #1;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f75);
        op = o; funct3 = f3; funct75 = f75;
        ZF = 1'b0; SF = 1'b0; VF = 1'b0; CF = 1'b0;
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; mem_ready = 1'b1;
        instr(7'd0, 3'd0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_a", 32'(va), 32'd0);
            chk("reset_b", 32'(vb), 32'd0);
        end
        rst_a_n = 1'b1;
        #1;
        chk("release_a_reset_state", 32'(va), 32'd0);
        @(posedge clk); #1;

        // lw, two wait states in MEMREAD: reg_write on the 7th cycle
        instr(7'b0000011, 3'b010, 1'b0);
        step(1, FA, "lw_fetch"); step(1, DC, "lw_dec"); step(1, MA_L, "lw_adr");
        step(0, MR, "lw_rd_w0"); step(0, MR, "lw_rd_w1"); step(1, MR, "lw_rd");
        step(1, MWB, "lw_wb");

        // bltu, CF=0 -> taken; preceded by one fetch wait
        instr(7'b1100011, 3'b110, 1'b0); CF = 1'b0;
        step(0, FW, "bltu_fwait"); step(1, FA, "bltu_fetch"); step(1, DC, "bltu_dec");
        step(1, BR1, "bltu_taken");
        instr(7'b1100011, 3'b110, 1'b0); CF = 1'b1;
        step(1, FA, "bltu2_fetch"); step(1, DC, "bltu2_dec"); step(1, BR0, "bltu_not_taken");
        instr(7'b1100011, 3'b101, 1'b0); SF = 1'b1; VF = 1'b1;
        step(1, FA, "bge_fetch"); step(1, DC, "bge_dec"); step(1, BR1, "bge_taken");
        // reserved branch funct3 falls into ILLEGAL after the compare cycle
        instr(7'b1100011, 3'b010, 1'b0); ZF = 1'b1;
        step(1, FA, "b010_fetch"); step(1, DC, "b010_dec"); step(1, BR0, "b010_br");
        step(1, ILL, "b010_illegal");

        // ALU decode: SRA, SUB, ADDI (not SUB), SRAI
        instr(7'b0110011, 3'b101, 1'b1);
        step(1, FA, "sra_fetch"); step(1, DC, "sra_dec");
        step(1, ov(0,0,0,0,0,0, 2,0,0,0, 7,0), "sra_exec"); step(1, AWB, "sra_wb");
        instr(7'b0110011, 3'b000, 1'b1);
        step(1, FA, "sub_fetch"); step(1, DC, "sub_dec");
        step(1, ov(0,0,0,0,0,0, 2,0,0,0, 1,0), "sub_exec"); step(1, AWB, "sub_wb");
        instr(7'b0010011, 3'b000, 1'b1);
        step(1, FA, "addi_fetch"); step(1, DC, "addi_dec");
        step(1, ov(0,0,0,0,0,0, 2,1,0,0, 0,0), "addi_exec"); step(1, AWB, "addi_wb");
        instr(7'b0010011, 3'b101, 1'b1);
        step(1, FA, "srai_fetch"); step(1, DC, "srai_dec");
        step(1, ov(0,0,0,0,0,0, 2,1,0,0, 7,0), "srai_exec"); step(1, AWB, "srai_wb");

        // unsupported opcode: single illegal pulse, no enables
        instr(7'b1111111, 3'b000, 1'b0);
        step(1, FA, "ill_fetch"); step(1, DC, "ill_dec"); step(1, ILL, "ill_pulse");

        // sw with one wait state; address/write held until accepted
        instr(7'b0100011, 3'b010, 1'b0);
        step(1, FA, "sw_fetch"); step(1, DC, "sw_dec"); step(1, MA_S, "sw_adr");
        step(0, MW, "sw_w0"); step(1, MW, "sw_acc");

        instr(7'b0110111, 3'b000, 1'b0);
        step(1, FA, "lui_fetch"); step(1, DC, "lui_dec"); step(1, LUIV, "lui_exec");
        step(1, AWB, "lui_wb");
        instr(7'b0010111, 3'b000, 1'b0);
        step(1, FA, "auipc_fetch"); step(1, DC, "auipc_dec"); step(1, AUIV, "auipc_exec");
        step(1, AWB, "auipc_wb");
        instr(7'b1101111, 3'b000, 1'b0);
        step(1, FA, "jal_fetch"); step(1, DC, "jal_dec"); step(1, JALV, "jal_pc");
        step(1, LWB, "jal_link");
        instr(7'b1100111, 3'b000, 1'b0);
        step(1, FA, "jalr_fetch"); step(1, DC, "jalr_dec"); step(1, JLRV, "jalr_pc");
        step(1, LWB, "jalr_link");

        // a is now in FETCH: reset there must silence mem_req at once.
        instr(7'b0100011, 3'b010, 1'b0);
        rst_a_n = 1'b0; rst_b_n = 1'b1;
        #1;
        chk("midfetch_reset_a", 32'(va), 32'd0);
        chk("release_b_reset_state", 32'(vb), 32'd0);
        @(posedge clk); #1;

        // b ignores mem_ready (tied 0): sw done in 4 cycles, then FETCH again
        step_b(FA, "sw_nowait_fetch"); step_b(DC, "sw_nowait_dec");
        step_b(MA_S, "sw_nowait_adr"); step_b(MW, "sw_nowait_wr");
        step_b(FA, "sw_nowait_next_fetch");
        rst_b_n = 1'b0;
        @(posedge clk); #1;

        chk("a_expected_left", 32'(qa.size()), 32'd0);
        chk("b_expected_left", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
